// File: rtl/mersenne_mod_acc.sv
// Reduces 2W-bit products modulo the Mersenne prime P = 2^W - 1 and sums the residues
// modulo P over groups that end on a last-flagged term. Fully pipelined, always ready.
module mersenne_mod_acc #(
  parameter int W  = 61,
  parameter int CW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2*W-1:0]  prod,
  input  logic            in_valid,
  input  logic            in_last,
  output logic [W-1:0]    out_res,
  output logic            out_valid,
  output logic [W-1:0]    acc_res,
  output logic [CW-1:0]   acc_cnt,
  output logic            acc_valid
);

  localparam logic [W-1:0]  P       = {W{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  // 2^W == 1 (mod P), so the high half folds onto the low half.
  function automatic logic [W:0] fold_hi(input logic [2*W-1:0] x);
    return {1'b0, x[W-1:0]} + {1'b0, x[2*W-1:W]};
  endfunction

  // The second fold cannot carry out; P itself is the only non-canonical result.
  function automatic logic [W-1:0] fold_canon(input logic [W:0] s);
    logic [W-1:0] r;
    r = s[W-1:0] + {{(W-1){1'b0}}, s[W]};
    return (r == P) ? '0 : r;
  endfunction

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] t;
    logic [W:0] d;
    t = {1'b0, a} + {1'b0, b};
    d = t - {1'b0, P};
    return (t >= {1'b0, P}) ? d[W-1:0] : t[W-1:0];
  endfunction

  logic [2*W-1:0] prod_p0;
  logic           vld_p0, last_p0;
  logic [W:0]     s1_p1;
  logic           vld_p1, last_p1;
  logic           last_p2;
  logic [W-1:0]   acc;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   acc_sum;

  assign acc_sum = mod_add(acc, out_res);

  // Data path registers: no reset, qualified by the valid bits travelling alongside.
  always_ff @(posedge clk) begin
    // p0: input capture
    prod_p0 <= prod;
    // p1: first fold
    s1_p1   <= fold_hi(prod_p0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p0    <= 1'b0;
      last_p0   <= 1'b0;
      vld_p1    <= 1'b0;
      last_p1   <= 1'b0;
      out_valid <= 1'b0;
      last_p2   <= 1'b0;
      out_res   <= '0;
      acc       <= '0;
      cnt       <= '0;
      acc_res   <= '0;
      acc_cnt   <= '0;
      acc_valid <= 1'b0;
    end else begin
      // p0: a last flag without a valid term is discarded here
      vld_p0    <= in_valid;
      last_p0   <= in_valid & in_last;
      // p1
      vld_p1    <= vld_p0;
      last_p1   <= last_p0;
      // p2: canonical residue
      out_valid <= vld_p1;
      last_p2   <= last_p1;
      if (vld_p1) out_res <= fold_canon(s1_p1);
      // accumulator: a closing term hands off its sum and restarts the group on the same edge
      acc_valid <= out_valid & last_p2;
      if (out_valid) begin
        if (last_p2) begin
          acc_res <= acc_sum;
          acc_cnt <= cnt + CNT_ONE;
          acc     <= '0;
          cnt     <= '0;
        end else begin
          acc     <= acc_sum;
          cnt     <= cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_mersenne_mod_acc.sv
// Scoreboard bench for mersenne_mod_acc: a wide-integer mod-P reference model feeds
// expected residues and group sums into queues that a negedge monitor drains.
module tb_mersenne_mod_acc;
  localparam int W  = 61;
  localparam int CW = 16;
  localparam logic [127:0] P128 = (128'd1 << W) - 128'd1;

  logic            clk = 1'b0;
  logic            reset;
  logic [2*W-1:0]  prod;
  logic            in_valid;
  logic            in_last;
  logic [W-1:0]    out_res;
  logic            out_valid;
  logic [W-1:0]    acc_res;
  logic [CW-1:0]   acc_cnt;
  logic            acc_valid;

  mersenne_mod_acc #(.W(W), .CW(CW)) dut (
    .clk(clk), .reset(reset), .prod(prod), .in_valid(in_valid), .in_last(in_last),
    .out_res(out_res), .out_valid(out_valid), .acc_res(acc_res), .acc_cnt(acc_cnt),
    .acc_valid(acc_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nchk = 0;
  int nerr = 0;

  logic [W-1:0]  exp_res_q[$];
  int            exp_res_cyc[$];
  logic [W-1:0]  exp_acc_q[$];
  logic [CW-1:0] exp_cnt_q[$];
  int            exp_acc_cyc[$];

  // reference group state: plain arbitrary-width arithmetic
  logic [127:0] gsum = '0;
  int           gcnt = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
    nchk++;
    if (got !== expv) begin
      nerr++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  task automatic send(input logic [2*W-1:0] p, input bit last, input bit keep);
    logic [127:0] r;
    @(negedge clk);
    prod = p; in_valid = 1'b1; in_last = last;
    if (keep) begin
      r = {6'b0, p} % P128;
      exp_res_q.push_back(r[W-1:0]);
      exp_res_cyc.push_back(cyc + 3);
      gsum = (gsum + r) % P128;
      gcnt++;
      if (last) begin
        exp_acc_q.push_back(gsum[W-1:0]);
        exp_cnt_q.push_back(CW'(gcnt));
        exp_acc_cyc.push_back(cyc + 4);
        gsum = '0;
        gcnt = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    logic [127:0] junk;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      junk = {$urandom, $urandom, $urandom, $urandom};
      prod = junk[2*W-1:0]; in_valid = 1'b0; in_last = 1'($urandom);
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1; prod = 122'd77; in_valid = 1'b1; in_last = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    gsum = '0;
    gcnt = 0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_res",   out_res,   0);
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_res",   acc_res,   0);
    check("rst_acc_cnt",   acc_cnt,   0);
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      if (exp_res_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_out_valid got out_res=%0h expected no output (cycle %0d)", out_res, cyc);
      end else begin
        check("out_res", out_res, exp_res_q.pop_front());
        check("out_latency", cyc, exp_res_cyc.pop_front());
      end
    end
    if (acc_valid) begin
      if (exp_acc_q.size() == 0) begin
        nchk++; nerr++;
        $display("FAIL unexpected_acc_valid got acc_res=%0h acc_cnt=%0d expected no pulse (cycle %0d)", acc_res, acc_cnt, cyc);
      end else begin
        check("acc_res", acc_res, exp_acc_q.pop_front());
        check("acc_cnt", acc_cnt, exp_cnt_q.pop_front());
        check("acc_latency", cyc, exp_acc_cyc.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] t;
    logic [2*W-1:0] p;
    reset = 1'b1; prod = '0; in_valid = 1'b0; in_last = 1'b0;
    do_reset(2);

    // zero product, then single-term corner products
    send('0, 1'b0, 1'b1);
    idle(4);
    t = P128;                         send(t[2*W-1:0], 1'b0, 1'b1);
    t = (P128 - 1) * (P128 - 1);      send(t[2*W-1:0], 1'b0, 1'b1);
    t = (128'd1 << (2*W)) - 1;        send(t[2*W-1:0], 1'b0, 1'b1);
    t = 128'd1 << W;                  send(t[2*W-1:0], 1'b0, 1'b1);
    t = P128 * P128;                  send(t[2*W-1:0], 1'b1, 1'b1);
    idle(5);

    // back-to-back group of three, then single-term groups, then the same group with bubbles
    t = P128 - 1;
    send(122'd5, 1'b0, 1'b1); send(122'd7, 1'b0, 1'b1); send(t[2*W-1:0], 1'b1, 1'b1);
    send(122'd3, 1'b1, 1'b1); send(122'd4, 1'b1, 1'b1);
    idle(2);
    send(122'd5, 1'b0, 1'b1); idle(3); send(122'd7, 1'b0, 1'b1); idle(1);
    send(t[2*W-1:0], 1'b1, 1'b1);
    idle(6);

    // mid-group reset: the two in-flight terms must vanish
    send(122'd9, 1'b0, 1'b0); send(122'd10, 1'b0, 1'b0);
    do_reset(1);
    send(122'd2, 1'b1, 1'b1);
    idle(6);

    // random soak
    for (int i = 0; i < 10000; i++) begin
      case ($urandom_range(0, 9))
        0:       t = (128'd1 << (2*W)) - 1;
        1:       t = P128 * P128 + $urandom_range(0, 3);
        2:       t = P128 * {96'd0, $urandom};
        default: t = {$urandom, $urandom, $urandom, $urandom};
      endcase
      p = t[2*W-1:0];
      send(p, ($urandom_range(0, 3) == 0), 1'b1);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    send(122'd1, 1'b1, 1'b1);
    idle(2);
    for (int i = 0; i < 20 && (exp_res_q.size() != 0 || exp_acc_q.size() != 0); i++)
      @(negedge clk);
    check("drain_res_queue", exp_res_q.size(), 0);
    check("drain_acc_queue", exp_acc_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule
